// File: rtl/lfsr_arb_if.sv
// Consumer-side bus of the shared LFSR arbiter.
//   req     : level requests, bit n = requester n
//   ack     : one-cycle one-hot pulse marking the word on rdata for that requester
//   rdata   : returned random word, held until the next ack
//   busy    : controller is not idle
//   seed_wr : one-cycle strobe capturing seed_in as the pending seed
//   seed_in : seed value
// master = consumer side, slave = controller side.
interface lfsr_arb_if #(
  parameter int WIDTH = 26
) ();
  logic [1:0]       req;
  logic [1:0]       ack;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             seed_wr;
  logic [WIDTH-1:0] seed_in;

  modport master (
    output req, seed_wr, seed_in,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, seed_wr, seed_in,
    output ack, rdata, busy
  );
endinterface

// File: rtl/lfsr_arb_ctrl.sv
// Controller and two-way arbiter in front of a single shared LFSR core.
// Seeds the LFSR after reset and on software seed writes, advances it STEPS
// times per granted request, and hands the resulting word back with a
// one-cycle ack. Recovers from the all-zero lock-up state by reseeding.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   bus       : consumer bus (req/ack/rdata/busy/seed_wr/seed_in), slave side
//   lfsr_load : LFSR synchronous load strobe
//   lfsr_din  : LFSR parallel load data
//   lfsr_en   : LFSR shift enable, one shift per enabled edge
//   lfsr_q    : current LFSR state
//
// Parameters: WIDTH (data width), STEPS (shifts per request, 1..255),
//             SEED (default seed; also used whenever a written seed is 0).
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | load SEED into the LFSR (after reset and on zero lock-up)
// IDLE  | wait; pending seed > zero recovery > grant a request
// LOAD  | load the pending seed (SEED if the pending seed is 0)
// RUN   | LFSR enabled; counts down STEPS enabled cycles
// DONE  | capture lfsr_q into rdata and pulse ack for the owner
module lfsr_arb_ctrl #(
  parameter int               WIDTH = 26,
  parameter int               STEPS = 4,
  parameter logic [WIDTH-1:0] SEED  = 26'h3656B59
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_arb_if.slave        bus,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_din,
  output logic             lfsr_en,
  input  logic [WIDTH-1:0] lfsr_q
);

  localparam logic [7:0] STEPS_CNT = 8'(STEPS);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q;
  logic             owner_q;
  logic             last_served_q;
  logic             pending_q;
  logic [WIDTH-1:0] pend_seed_q;
  logic [1:0]       ack_q;
  logic [WIDTH-1:0] rdata_q;

  logic             grant;
  logic             grant_owner;

  // When both request, the one not served last wins; otherwise the single
  // active requester wins (req[1] alone selects owner 1).
  always_comb begin
    if (bus.req == 2'b11) begin
      grant_owner = ~last_served_q;
    end else begin
      grant_owner = bus.req[1];
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_LOAD: state_d = S_IDLE;
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_LOAD;
        end else if (lfsr_q == '0) begin
          state_d = S_INIT;
        end else if (|bus.req) begin
          grant   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // terminal count: the cycle with cnt==1 is the last enabled one
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Moore decode of the LFSR controls; the reset state is INIT, so during
  // reset the LFSR is held loading SEED.
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_din  = '0;
    lfsr_en   = 1'b0;
    case (state_q)
      S_INIT: begin
        lfsr_load = 1'b1;
        lfsr_din  = SEED;
      end
      S_LOAD: begin
        lfsr_load = 1'b1;
        lfsr_din  = (pend_seed_q == '0) ? SEED : pend_seed_q;
      end
      S_RUN:   lfsr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= 8'd0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      pending_q     <= 1'b0;
      pend_seed_q   <= '0;
      ack_q         <= 2'b00;
      rdata_q       <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= 2'b00;

      if (grant) begin
        owner_q <= grant_owner;
        cnt_q   <= STEPS_CNT;
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q - 8'd1;
      end

      if (state_q == S_DONE) begin
        rdata_q       <= lfsr_q;
        ack_q         <= owner_q ? 2'b10 : 2'b01;
        last_served_q <= owner_q;
      end

      // A write in the LOAD cycle itself survives as a new pending seed.
      if (bus.seed_wr) begin
        pending_q   <= 1'b1;
        pend_seed_q <= bus.seed_in;
      end else if (state_q == S_LOAD) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
module tb_lfsr_arb_ctrl;
  localparam int          WIDTH = 26;
  localparam int          STEPS = 4;
  localparam logic [25:0] SEED  = 26'h3656B59;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lfsr_load, lfsr_en;
  logic [WIDTH-1:0]  lfsr_din, lfsr_q, stub_q;
  logic              stub_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_arb_if #(.WIDTH(WIDTH)) bus ();

  lfsr_arb_ctrl #(.WIDTH(WIDTH), .STEPS(STEPS), .SEED(SEED)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .lfsr_load(lfsr_load),
    .lfsr_din (lfsr_din),
    .lfsr_en  (lfsr_en),
    .lfsr_q   (lfsr_q)
  );

  // LFSR core stub: x^26+x^6+x^2+x+1 Fibonacci, shifting left.
  always @(posedge clk) begin
    if (lfsr_load)    stub_q <= lfsr_din;
    else if (lfsr_en) stub_q <= {stub_q[24:0], ^{stub_q[25], stub_q[5], stub_q[1], stub_q[0]}};
  end
  assign lfsr_q = stub_zero ? '0 : stub_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] adv(input logic [25:0] x, input int n);
    logic [25:0] v;
    v = x;
    for (int k = 0; k < n; k++) v = {v[24:0], v[25] ^ v[5] ^ v[1] ^ v[0]};
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // m_kind: 0 idle, 1 reseed with SEED, 2 load pending seed, 3 transaction.
  // m_age counts cycles into a transaction (1..STEPS shifting, STEPS+1 capture).
  int          m_kind, m_age, m_owner, m_last;
  logic        m_pend;
  logic [25:0] m_pseed, m_val, m_rdata;
  logic [1:0]  m_ack;

  task automatic model_reset();
    m_kind = 1; m_age = 0; m_owner = 0; m_last = 1;
    m_pend = 1'b0; m_pseed = '0; m_val = SEED; m_rdata = '0; m_ack = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] r;
    logic [1:0] nack;
    r    = bus.req;
    nack = 2'b00;
    case (m_kind)
      1: begin m_kind = 0; m_val = SEED; end
      2: begin m_kind = 0; m_val = (m_pseed == 0) ? SEED : m_pseed; m_pend = 1'b0; end
      3: begin
        if (m_age == STEPS + 1) begin
          m_val   = adv(m_val, STEPS);
          m_rdata = m_val;
          nack    = (m_owner == 1) ? 2'b10 : 2'b01;
          m_last  = m_owner;
          m_kind  = 0;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (m_pend) m_kind = 2;
        else if (stub_zero) m_kind = 1;
        else if (r != 2'b00) begin
          m_owner = (r == 2'b11) ? 1 - m_last : ((r == 2'b10) ? 1 : 0);
          m_kind  = 3;
          m_age   = 1;
        end
      end
    endcase
    m_ack = nack;
    if (bus.seed_wr) begin
      m_pend  = 1'b1;
      m_pseed = bus.seed_in;
    end
  endtask

  task automatic compare_all();
    logic [25:0] e_din;
    e_din = (m_kind == 1) ? SEED : (m_kind == 2) ? ((m_pseed == 0) ? SEED : m_pseed) : 26'd0;
    chk("m_load",  {31'd0, lfsr_load}, {31'd0, (m_kind == 1 || m_kind == 2)});
    chk("m_din",   {6'd0, lfsr_din}, {6'd0, e_din});
    chk("m_en",    {31'd0, lfsr_en}, {31'd0, (m_kind == 3 && m_age <= STEPS)});
    chk("m_busy",  {31'd0, bus.busy}, {31'd0, (m_kind != 0)});
    chk("m_ack",   {30'd0, bus.ack}, {30'd0, m_ack});
    chk("m_rdata", {6'd0, bus.rdata}, {6'd0, m_rdata});
  endtask

  // single compare process: model advances on rising edges, outputs checked
  // on falling edges and just after an asynchronous reset assertion
  always begin
    @(posedge clk or negedge clk or posedge rst);
    if (rst) begin
      model_reset();
      #1 compare_all();
    end else if (clk) begin
      model_step();
    end else begin
      compare_all();
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic single_req(input string tag);
    logic [11:0] en_m, ack_m;
    en_m = '0; ack_m = '0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      bus.req = (i == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      en_m[i]  = lfsr_en;
      ack_m[i] = (bus.ack == 2'b01);
    end
    chk({tag, "_en_cycles"}, {20'd0, en_m}, 32'h01E);
    chk({tag, "_ack_cycle"}, {20'd0, ack_m}, 32'h040);
  endtask

  initial begin
    int          ack_idx[$];
    logic [1:0]  ack_val[$];
    logic [11:0] ack_m;

    bus.req = 2'b00; bus.seed_wr = 1'b0; bus.seed_in = '0; stub_zero = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("init_load", {31'd0, lfsr_load}, 32'd1);
    chk("init_din",  {6'd0, lfsr_din}, 32'h3656B59);
    chk("init_busy", {31'd0, bus.busy}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("idle_busy",  {31'd0, bus.busy}, 32'd0);
    chk("idle_ack",   {30'd0, bus.ack}, 32'd0);
    chk("idle_rdata", {6'd0, bus.rdata}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("idle_quiet", {30'd0, lfsr_load, lfsr_en}, 32'd0);
    end

    // both requesters held: alternate, 6 cycles apart, requester 0 first
    for (int i = 0; i < 36; i++) begin
      next_cycle();
      bus.req = (i <= 20) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        ack_idx.push_back(i);
        ack_val.push_back(bus.ack);
      end
    end
    chk("pair_count", ack_idx.size(), 32'd4);
    for (int k = 0; k < ack_idx.size() && k < 4; k++) begin
      chk("pair_cycle", ack_idx[k], 6 * (k + 1));
      chk("pair_owner", {30'd0, ack_val[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end

    single_req("single");

    // seed write during RUN is deferred until after the ack
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      bus.req     = (i == 0 || i == 8) ? 2'b01 : 2'b00;
      bus.seed_wr = (i == 2);
      bus.seed_in = (i == 2) ? 26'h0000001 : 26'h0;
      @(negedge clk);
      if (i == 6) chk("sd_old_ack", {30'd0, bus.ack}, 32'd1);
      if (i == 7) begin
        chk("sd_load", {31'd0, lfsr_load}, 32'd1);
        chk("sd_din",  {6'd0, lfsr_din}, 32'h1);
      end
      if (i == 14) begin
        chk("sd_ack",  {30'd0, bus.ack}, 32'd1);
        chk("sd_word", {6'd0, bus.rdata}, 32'h000001B);
      end
    end

    // zero seed write falls back to SEED
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.seed_wr = (i == 0);
      bus.seed_in = '0;
      @(negedge clk);
      if (i == 2) begin
        chk("zs_load", {31'd0, lfsr_load}, 32'd1);
        chk("zs_din",  {6'd0, lfsr_din}, 32'h3656B59);
      end
    end

    // lock-up recovery wins over a pending request
    ack_m = '0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      stub_zero = (i == 0);
      bus.req   = (i <= 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (i == 1) begin
        chk("zl_load", {31'd0, lfsr_load}, 32'd1);
        chk("zl_din",  {6'd0, lfsr_din}, 32'h3656B59);
        chk("zl_noen", {31'd0, lfsr_en}, 32'd0);
      end
      ack_m[i] = (bus.ack == 2'b01);
    end
    chk("zl_ack_cycle", {20'd0, ack_m}, 32'h100);

    // asynchronous reset pulse in the middle of RUN
    ack_m = '0;
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      bus.req = (i == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (i == 2) begin
        #1 rst = 1'b1;
        #1;
        chk("mr_en",   {31'd0, lfsr_en}, 32'd0);
        chk("mr_busy", {31'd0, bus.busy}, 32'd1);
        chk("mr_load", {31'd0, lfsr_load}, 32'd1);
        #1 rst = 1'b0;
      end
      ack_m[i] = |bus.ack;
    end
    chk("mr_no_ack", {20'd0, ack_m}, 32'd0);
    single_req("post_rst");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      bus.req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        bus.seed_wr = 1'b1;
        bus.seed_in = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom());
      end else begin
        bus.seed_wr = 1'b0;
      end
    end
    next_cycle();
    bus.req = 2'b00;
    bus.seed_wr = 1'b0;
    repeat (20) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
